alu: RTL and testbench



---
 rtl/alu_if.sv | 34 +++
 rtl/alu.sv | 117 +++++++++++
 tb/tb_alu.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Operand/result bundle between the datapath and the ALU.
interface alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [2:0]       alu_control;
    logic [1:0]       flag_write;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;
    logic [3:0]       flags_q;

    // Datapath side: supplies operands and consumes result/flags.
    modport master (
        output src_a,
        output src_b,
        output alu_control,
        output flag_write,
        input  alu_result,
        input  alu_flags,
        input  flags_q
    );

    // ALU side.
    modport slave (
        input  src_a,
        input  src_b,
        input  alu_control,
        input  flag_write,
        output alu_result,
        output alu_flags,
        output flags_q
    );
endinterface

// File: rtl/alu.sv
// ARM-style integer ALU: combinational result and NZCV flags from a single
// shared adder, plus an architectural flags register with split NZ / CV
// write enables.
module alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic  clk,
    input  logic  reset,
    alu_if.slave  bus
);
    localparam int unsigned SUM_W = WIDTH + 1;
    localparam int unsigned MSB   = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_ORR = 3'b011,
        OP_EOR = 3'b100,
        OP_RSB = 3'b101,
        OP_ADC = 3'b110,
        OP_MOV = 3'b111
    } alu_op_e;

    alu_op_e          op;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic             is_arith;
    logic [SUM_W-1:0] sum;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic [3:0]       flags_r;

    assign op = alu_op_e'(bus.alu_control);

    // Steer operands into the shared adder; subtraction is x + ~y + 1.
    always_comb begin
        add_x    = bus.src_a;
        add_y    = bus.src_b;
        add_cin  = 1'b0;
        is_arith = 1'b0;
        unique case (op)
            OP_ADD: begin
                is_arith = 1'b1;
            end
            OP_SUB: begin
                add_y    = ~bus.src_b;
                add_cin  = 1'b1;
                is_arith = 1'b1;
            end
            OP_RSB: begin
                add_x    = bus.src_b;
                add_y    = ~bus.src_a;
                add_cin  = 1'b1;
                is_arith = 1'b1;
            end
            OP_ADC: begin
                // Carry-in comes from the registered flag only, so no loop
                // through the flag write path.
                add_cin  = flags_r[1];
                is_arith = 1'b1;
            end
            default: begin
                is_arith = 1'b0;
            end
        endcase
    end

    // Single 33-bit adder; bit WIDTH is the carry-out.
    assign sum = SUM_W'(add_x) + SUM_W'(add_y) + SUM_W'(add_cin);

    // Result select.
    always_comb begin
        result = sum[WIDTH-1:0];
        unique case (op)
            OP_AND:  result = bus.src_a & bus.src_b;
            OP_ORR:  result = bus.src_a | bus.src_b;
            OP_EOR:  result = bus.src_a ^ bus.src_b;
            OP_MOV:  result = bus.src_b;
            default: result = sum[WIDTH-1:0];
        endcase
    end

    // NZCV for the current operation; C and V only meaningful for adder ops.
    always_comb begin
        flag_n = result[MSB];
        flag_z = (result == '0);
        flag_c = 1'b0;
        flag_v = 1'b0;
        if (is_arith) begin
            flag_c = sum[WIDTH];
            flag_v = (add_x[MSB] == add_y[MSB]) && (sum[MSB] != add_x[MSB]);
        end
    end

    assign bus.alu_result = result;
    assign bus.alu_flags  = {flag_n, flag_z, flag_c, flag_v};
    assign bus.flags_q    = flags_r;

    // Architectural flags: NZ and CV groups load independently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r <= 4'b0000;
        end else begin
            if (bus.flag_write[1]) begin
                flags_r[3:2] <= {flag_n, flag_z};
            end
            if (bus.flag_write[0]) begin
                flags_r[1:0] <= {flag_c, flag_v};
            end
        end
    end
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors with literal expectations
// plus a per-cycle comparison against an arithmetic reference model.
module tb_alu;
    logic clk;
    logic reset;

    alu_if #(.WIDTH(32)) bus ();

    alu #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic        check_en = 1'b0;
    logic [3:0]  model_fq = 4'b0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: wide signed/unsigned arithmetic, returns {result, N, Z, C, V}.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic cin);
        longint          sa;
        longint          sb;
        longint          sr;
        longint unsigned ua;
        longint unsigned ub;
        logic [31:0]     r;
        logic            c;
        logic            v;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = longint'(a);
        ub = longint'(b);
        sr = 0;
        c  = 1'b0;
        r  = 32'h0;
        case (op)
            3'd0: begin r = 32'(ua + ub); c = (ua + ub) > 64'hFFFF_FFFF; sr = sa + sb; end
            3'd1: begin r = 32'(ua - ub); c = (ua >= ub); sr = sa - sb; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = 32'(ub - ua); c = (ub >= ua); sr = sb - sa; end
            3'd6: begin
                r  = 32'(ua + ub + longint'(cin));
                c  = (ua + ub + longint'(cin)) > 64'hFFFF_FFFF;
                sr = sa + sb + longint'(cin);
            end
            default: r = b;
        endcase
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {r, r[31], (r == 32'h0), c, v};
    endfunction

    // Model of the flags register.
    always @(posedge clk or posedge reset) begin
        logic [35:0] m;
        if (reset) begin
            model_fq = 4'b0000;
        end else begin
            m = model(bus.src_a, bus.src_b, bus.alu_control, model_fq[1]);
            if (bus.flag_write[1]) model_fq[3:2] = m[3:2];
            if (bus.flag_write[0]) model_fq[1:0] = m[1:0];
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [35:0] m;
        if (check_en) begin
            m = model(bus.src_a, bus.src_b, bus.alu_control, model_fq[1]);
            check("cyc_result", bus.alu_result, m[35:4]);
            check("cyc_flags", 32'(bus.alu_flags), 32'(m[3:0]));
            check("cyc_flags_q", 32'(bus.flags_q), 32'(model_fq));
        end
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] fw);
        @(negedge clk);
        #1;
        bus.alu_control = op;
        bus.src_a       = a;
        bus.src_b       = b;
        bus.flag_write  = fw;
        #1;
    endtask

    // Directed vector with hand-computed result and flags; also pins the model.
    task automatic vec(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_r, input logic [3:0] exp_f);
        logic [35:0] m;
        drive(op, a, b, 2'b00);
        check({name, "_res"}, bus.alu_result, exp_r);
        check({name, "_flags"}, 32'(bus.alu_flags), 32'(exp_f));
        m = model(a, b, op, model_fq[1]);
        check({name, "_model"}, m[35:0] == {exp_r, exp_f} ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic expect_fq(input string name, input logic [3:0] exp);
        @(posedge clk);
        #1;
        check(name, 32'(bus.flags_q), 32'(exp));
    endtask

    initial begin
        reset           = 1'b1;
        bus.src_a       = 32'h0;
        bus.src_b       = 32'h0;
        bus.alu_control = 3'b000;
        bus.flag_write  = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        check("reset_fq", 32'(bus.flags_q), 32'h0);
        reset    = 1'b0;
        check_en = 1'b1;

        vec("add_ovf",  3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
        vec("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
        vec("sub_eq",   3'd1, 32'd5,         32'd5,         32'h0000_0000, 4'b0110);
        vec("sub_neg",  3'd1, 32'd3,         32'd5,         32'hFFFF_FFFE, 4'b1000);
        vec("sub_ovf",  3'd1, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 4'b0011);
        vec("and",      3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000);
        vec("orr",      3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 4'b1000);
        vec("eor",      3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000);
        vec("mov",      3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFF00_FF00, 4'b1000);
        vec("rsb",      3'd5, 32'd2,         32'd7,         32'h0000_0005, 4'b0010);
        vec("rsb_eq",   3'd5, 32'd5,         32'd5,         32'h0000_0000, 4'b0110);
        vec("rsb_ovf",  3'd5, 32'd1,         32'h8000_0000, 32'h7FFF_FFFF, 4'b0011);
        vec("adc_c0",   3'd6, 32'd1,         32'd1,         32'h0000_0002, 4'b0000);
        expect_fq("fq_untouched", 4'b0000);

        // Flags register and carry-in sequence.
        drive(3'd0, 32'hFFFF_FFFF, 32'd1, 2'b01);
        expect_fq("fq_cv_only", 4'b0010);
        vec("adc_c1",   3'd6, 32'd1,         32'd1,         32'h0000_0003, 4'b0000);
        drive(3'd6, 32'd1, 32'd1, 2'b10);
        expect_fq("fq_nz_only", 4'b0010);
        vec("adc_wrap", 3'd6, 32'hFFFF_FFFF, 32'd0,         32'h0000_0000, 4'b0110);
        vec("adc_ovf",  3'd6, 32'h7FFF_FFFF, 32'd0,         32'h8000_0000, 4'b1001);
        // ADC loading its own carry: uses old C=1, produces C=0.
        drive(3'd6, 32'h7FFF_FFFF, 32'd0, 2'b11);
        check("adc_load_res", bus.alu_result, 32'h8000_0000);
        expect_fq("fq_adc_load", 4'b1001);
        vec("adc_after", 3'd6, 32'd1,        32'd1,         32'h0000_0002, 4'b0000);

        // Asynchronous reset between edges.
        drive(3'd0, 32'hFFFF_FFFF, 32'd1, 2'b11);
        expect_fq("fq_0110", 4'b0110);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 32'(bus.flags_q), 32'h0);
        bus.flag_write = 2'b11;
        repeat (3) expect_fq("reset_hold", 4'b0000);
        @(negedge clk);
        #1;
        reset = 1'b0;
        drive(3'd1, 32'd3, 32'd5, 2'b11);
        expect_fq("post_reset", 4'b1000);

        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
